// File: rtl/alu_ctrl_issue.sv
// EX-stage ALU control register: decodes RV32 opcode/funct3/funct7 into a 4-bit ALU code.
// Also models multi-cycle MUL occupancy, during which the ID stage is backpressured.
module alu_ctrl_issue #(
    parameter int MUL_CYCLES = 3,
    parameter int CNT_W      = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic       stall_i,
    input  logic       flush_i,
    output logic       ready_o,
    output logic [3:0] ALUCtrl_o,
    output logic       valid_o,
    output logic       illegal_o,
    output logic       busy_o
);

    localparam logic [3:0] C_AND  = 4'b0000, C_XOR  = 4'b0001, C_SLL = 4'b0010,
                           C_ADD  = 4'b0011, C_SUB  = 4'b0100, C_MUL = 4'b0101,
                           C_ADDI = 4'b0110, C_SRAI = 4'b0111, C_LW  = 4'b1000,
                           C_SW   = 4'b1001, C_BEQ  = 4'b1010, C_ILL = 4'b1111;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    logic [3:0]       dec_code;
    logic             dec_ill;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        dec_code = C_ILL;
        case (opcode_i)
            7'b0110011: begin
                if (funct7_i == 7'b0000000) begin
                    case (funct3_i)
                        3'b111:  dec_code = C_AND;
                        3'b100:  dec_code = C_XOR;
                        3'b001:  dec_code = C_SLL;
                        3'b000:  dec_code = C_ADD;
                        default: dec_code = C_ILL;
                    endcase
                end else if (funct7_i == 7'b0100000 && funct3_i == 3'b000) begin
                    dec_code = C_SUB;
                end else if (funct7_i == 7'b0000001 && funct3_i == 3'b000) begin
                    dec_code = C_MUL;
                end
            end
            7'b0010011: begin
                // ADDI ignores funct7; SRAI needs the arithmetic-shift funct7
                if (funct3_i == 3'b000)
                    dec_code = C_ADDI;
                else if (funct3_i == 3'b101 && funct7_i == 7'b0100000)
                    dec_code = C_SRAI;
            end
            7'b0000011: if (funct3_i == 3'b010) dec_code = C_LW;
            7'b0100011: if (funct3_i == 3'b010) dec_code = C_SW;
            7'b1100011: if (funct3_i == 3'b000) dec_code = C_BEQ;
            default:    dec_code = C_ILL;
        endcase
        dec_ill = (dec_code == C_ILL);
    end

    assign busy_o  = (cnt != '0);
    assign ready_o = ~stall_i & ~busy_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            ALUCtrl_o <= 4'b0000;
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
            cnt       <= '0;
        end else if (busy_o) begin
            // MUL occupancy drains even under stall
            cnt <= cnt - 1'b1;
        end else if (stall_i) begin
            cnt <= cnt;
        end else if (valid_i) begin
            ALUCtrl_o <= dec_code;
            valid_o   <= 1'b1;
            illegal_o <= dec_ill;
            cnt       <= (dec_code == C_MUL) ? MUL_LOAD : '0;
        end else begin
            ALUCtrl_o <= 4'b0000;
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Scoreboard bench for alu_ctrl_issue: per-cycle stimulus tables with expected outputs queued.
module tb_alu_ctrl_issue;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       valid_i = 1'b0;
    logic [6:0] opcode_i = '0;
    logic [2:0] funct3_i = '0;
    logic [6:0] funct7_i = '0;
    logic       stall_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       ready_o;
    logic [3:0] ALUCtrl_o;
    logic       valid_o;
    logic       illegal_o;
    logic       busy_o;

    alu_ctrl_issue #(.MUL_CYCLES(3), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .opcode_i(opcode_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .stall_i(stall_i), .flush_i(flush_i),
        .ready_o(ready_o), .ALUCtrl_o(ALUCtrl_o), .valid_o(valid_o),
        .illegal_o(illegal_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // expected {code, valid, illegal, busy, ready}
    typedef struct packed {
        logic [3:0] code;
        logic       v, il, b, r;
    } exp_t;

    typedef struct packed {
        logic        rst, v, st, fl;
        logic [16:0] ins;
        exp_t        e;
    } step_t;

    // instruction = {opcode, funct3, funct7}
    localparam logic [16:0] I_AND  = {7'b0110011, 3'b111, 7'b0000000};
    localparam logic [16:0] I_XOR  = {7'b0110011, 3'b100, 7'b0000000};
    localparam logic [16:0] I_SLL  = {7'b0110011, 3'b001, 7'b0000000};
    localparam logic [16:0] I_ADD  = {7'b0110011, 3'b000, 7'b0000000};
    localparam logic [16:0] I_SUB  = {7'b0110011, 3'b000, 7'b0100000};
    localparam logic [16:0] I_MUL  = {7'b0110011, 3'b000, 7'b0000001};
    localparam logic [16:0] I_ADDI = {7'b0010011, 3'b000, 7'b1111111};
    localparam logic [16:0] I_SRAI = {7'b0010011, 3'b101, 7'b0100000};
    localparam logic [16:0] I_LW   = {7'b0000011, 3'b010, 7'b0000000};
    localparam logic [16:0] I_SW   = {7'b0100011, 3'b010, 7'b0000000};
    localparam logic [16:0] I_BEQ  = {7'b1100011, 3'b000, 7'b0000000};
    localparam logic [16:0] I_BAD  = {7'b1111111, 3'b000, 7'b0000000};
    localparam logic [16:0] I_SRLI = {7'b0010011, 3'b101, 7'b0000000};
    localparam logic [16:0] I_MULH = {7'b0110011, 3'b001, 7'b0000001};

    exp_t sbq[$];
    int   passed = 0;
    int   total  = 0;

    function automatic step_t S(input logic r, v, st, fl, input logic [16:0] ins,
                                input logic [3:0] code, input logic ev, eil, eb, er);
        step_t s;
        s.rst = r; s.v = v; s.st = st; s.fl = fl; s.ins = ins;
        s.e.code = code; s.e.v = ev; s.e.il = eil; s.e.b = eb; s.e.r = er;
        return s;
    endfunction

    // drive one cycle of stimulus, queue its expectation, advance past the edge
    task automatic drive(input step_t s);
        rst_i = s.rst; valid_i = s.v; stall_i = s.st; flush_i = s.fl;
        {opcode_i, funct3_i, funct7_i} = s.ins;
        sbq.push_back(s.e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        step_t s[$];
        exp_t got, exp;
        s.push_back(S(1, 1, 0, 0, I_ADD, 4'h0, 0, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, I_ADD, 4'h0, 0, 0, 0, 1));
        foreach (s[i]) begin
            drive(s[i]);
            got = {ALUCtrl_o, valid_o, illegal_o, busy_o, ready_o};
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL test_reset step %0d: got %b want %b", i, got, exp);
            else passed++;
        end
    endtask

    task automatic test_sub();
        step_t s[$];
        exp_t got, exp;
        s.push_back(S(0, 1, 0, 0, I_SUB, 4'h4, 1, 0, 0, 1));
        s.push_back(S(0, 0, 0, 0, I_SUB, 4'h0, 0, 0, 0, 1));
        foreach (s[i]) begin
            drive(s[i]);
            got = {ALUCtrl_o, valid_o, illegal_o, busy_o, ready_o};
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL test_sub step %0d: got %b want %b", i, got, exp);
            else passed++;
        end
    endtask

    task automatic test_sweep();
        step_t s[$];
        exp_t got, exp;
        s.push_back(S(0, 1, 0, 0, I_AND,  4'h0, 1, 0, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_XOR,  4'h1, 1, 0, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_SLL,  4'h2, 1, 0, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_ADD,  4'h3, 1, 0, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_SUB,  4'h4, 1, 0, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_MUL,  4'h5, 1, 0, 1, 0));
        // ADDI held at ID until the multiplier frees
        s.push_back(S(0, 1, 0, 0, I_ADDI, 4'h5, 1, 0, 1, 0));
        s.push_back(S(0, 1, 0, 0, I_ADDI, 4'h5, 1, 0, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_ADDI, 4'h6, 1, 0, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_SRAI, 4'h7, 1, 0, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_LW,   4'h8, 1, 0, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_SW,   4'h9, 1, 0, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_BEQ,  4'hA, 1, 0, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_BAD,  4'hF, 1, 1, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_SRLI, 4'hF, 1, 1, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_MULH, 4'hF, 1, 1, 0, 1));
        s.push_back(S(0, 0, 0, 0, I_ADD,  4'h0, 0, 0, 0, 1));
        foreach (s[i]) begin
            drive(s[i]);
            got = {ALUCtrl_o, valid_o, illegal_o, busy_o, ready_o};
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL test_sweep step %0d: got %b want %b", i, got, exp);
            else passed++;
        end
    endtask

    task automatic test_mul_hold();
        step_t s[$];
        exp_t got, exp;
        s.push_back(S(0, 1, 0, 0, I_MUL, 4'h5, 1, 0, 1, 0));
        s.push_back(S(0, 1, 0, 0, I_ADD, 4'h5, 1, 0, 1, 0));
        s.push_back(S(0, 1, 0, 0, I_ADD, 4'h5, 1, 0, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_ADD, 4'h3, 1, 0, 0, 1));
        s.push_back(S(0, 0, 0, 0, I_ADD, 4'h0, 0, 0, 0, 1));
        foreach (s[i]) begin
            drive(s[i]);
            got = {ALUCtrl_o, valid_o, illegal_o, busy_o, ready_o};
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL test_mul_hold step %0d: got %b want %b", i, got, exp);
            else passed++;
        end
    endtask

    task automatic test_mul_stall();
        step_t s[$];
        exp_t got, exp;
        s.push_back(S(0, 1, 0, 0, I_MUL, 4'h5, 1, 0, 1, 0));
        s.push_back(S(0, 1, 1, 0, I_ADD, 4'h5, 1, 0, 1, 0));
        s.push_back(S(0, 1, 0, 0, I_ADD, 4'h5, 1, 0, 0, 1));
        s.push_back(S(0, 1, 1, 0, I_ADD, 4'h5, 1, 0, 0, 0));
        s.push_back(S(0, 1, 0, 0, I_ADD, 4'h3, 1, 0, 0, 1));
        s.push_back(S(0, 0, 0, 0, I_ADD, 4'h0, 0, 0, 0, 1));
        foreach (s[i]) begin
            drive(s[i]);
            got = {ALUCtrl_o, valid_o, illegal_o, busy_o, ready_o};
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL test_mul_stall step %0d: got %b want %b", i, got, exp);
            else passed++;
        end
    endtask

    task automatic test_flush();
        step_t s[$];
        exp_t got, exp;
        s.push_back(S(0, 1, 0, 0, I_MUL, 4'h5, 1, 0, 1, 0));
        s.push_back(S(0, 1, 0, 1, I_ADD, 4'h0, 0, 0, 0, 1));
        s.push_back(S(0, 1, 0, 1, I_SUB, 4'h0, 0, 0, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_BAD, 4'hF, 1, 1, 0, 1));
        s.push_back(S(0, 0, 0, 1, I_ADD, 4'h0, 0, 0, 0, 1));
        foreach (s[i]) begin
            drive(s[i]);
            got = {ALUCtrl_o, valid_o, illegal_o, busy_o, ready_o};
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL test_flush step %0d: got %b want %b", i, got, exp);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_mul();
        step_t s[$];
        exp_t got, exp;
        s.push_back(S(0, 1, 0, 0, I_MUL, 4'h5, 1, 0, 1, 0));
        s.push_back(S(1, 1, 0, 0, I_ADD, 4'h0, 0, 0, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_XOR, 4'h1, 1, 0, 0, 1));
        foreach (s[i]) begin
            drive(s[i]);
            got = {ALUCtrl_o, valid_o, illegal_o, busy_o, ready_o};
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL test_reset_mid_mul step %0d: got %b want %b", i, got, exp);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        exp_t got, exp;
        s.push_back(S(0, 1, 0, 0, I_MUL, 4'h5, 1, 0, 1, 0));
        s.push_back(S(0, 1, 0, 0, I_MUL, 4'h5, 1, 0, 1, 0));
        s.push_back(S(0, 1, 0, 0, I_MUL, 4'h5, 1, 0, 0, 1));
        s.push_back(S(0, 1, 0, 0, I_MUL, 4'h5, 1, 0, 1, 0));
        s.push_back(S(0, 0, 0, 0, I_MUL, 4'h5, 1, 0, 1, 0));
        s.push_back(S(0, 0, 0, 0, I_MUL, 4'h5, 1, 0, 0, 1));
        s.push_back(S(0, 0, 0, 0, I_MUL, 4'h0, 0, 0, 0, 1));
        foreach (s[i]) begin
            drive(s[i]);
            got = {ALUCtrl_o, valid_o, illegal_o, busy_o, ready_o};
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL test_back_to_back step %0d: got %b want %b", i, got, exp);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_sweep();
        test_mul_hold();
        test_mul_stall();
        test_flush();
        test_reset_mid_mul();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
